// File: rtl/issue_alloc_unit.sv
// Tomasulo issue/allocation stage: picks RS/LSQ and ROB slots, owns ROB/LSQ pointers.
// Optional stall/issue statistics counters are enabled with ISSUE_STALL_STATS_EN.
module issue_alloc_unit #(
   parameter int ROB_DEPTH = 8,
   parameter int N_ADD     = 3,
   parameter int N_MUL     = 2,
   parameter int LSQ_DEPTH = 6,
   localparam int RSW      = $clog2(LSQ_DEPTH + N_ADD + N_MUL + 1),
   localparam int ROB_W    = $clog2(ROB_DEPTH),
   localparam int LSQ_W    = $clog2(LSQ_DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             issue_valid,
   input  logic [2:0]       issue_op,
   input  logic [N_ADD-1:0] add_busy,
   input  logic [N_MUL-1:0] mul_busy,
   input  logic             rob_commit,
   input  logic             lsq_release,
   input  logic             flush,
   output logic             issue_ready,
   output logic [ROB_W-1:0] rob_idx,
   output logic [RSW-1:0]   rs_idx,
   output logic             struct_haz,
   output logic [1:0]       haz_cause,
   output logic             illegal_op,
   output logic [ROB_W:0]   rob_count,
   output logic [LSQ_W:0]   lsq_count
`ifdef ISSUE_STALL_STATS_EN
   ,
   output logic [31:0]      stall_rob_cnt,
   output logic [31:0]      stall_rs_cnt,
   output logic [31:0]      stall_lsq_cnt,
   output logic [31:0]      issue_cnt
`endif
);

   localparam int ADD_BASE = LSQ_DEPTH;
   localparam int MUL_BASE = LSQ_DEPTH + N_ADD;
   localparam int NONE_IDX = LSQ_DEPTH + N_ADD + N_MUL;

   localparam logic [RSW-1:0]   RS_NONE  = RSW'(NONE_IDX);
   localparam logic [ROB_W:0]   ROB_FULL = (ROB_W + 1)'(ROB_DEPTH);
   localparam logic [LSQ_W:0]   LSQ_FULL = (LSQ_W + 1)'(LSQ_DEPTH);
   localparam logic [LSQ_W-1:0] LSQ_LAST = LSQ_W'(LSQ_DEPTH - 1);

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_ROB  = 2'd1;
   localparam logic [1:0] CAUSE_RS   = 2'd2;
   localparam logic [1:0] CAUSE_LSQ  = 2'd3;

   logic [ROB_W-1:0] rob_head_reg, rob_head_next;
   logic [ROB_W-1:0] rob_tail_reg, rob_tail_next;
   logic [ROB_W:0]   rob_count_reg, rob_count_next;
   logic [LSQ_W-1:0] lsq_tail_reg, lsq_tail_next;
   logic [LSQ_W:0]   lsq_count_reg, lsq_count_next;

   logic             op_add, op_mul, op_mem, op_ill;
   logic             rob_full, lsq_full;
   logic             add_any_free, mul_any_free;
   logic [RSW-1:0]   add_sel, mul_sel;
   logic [1:0]       cause;
   logic             hazard;
   logic             fire, fire_mem, do_commit, do_release;

   assign op_add = (issue_op == 3'd0) || (issue_op == 3'd1);
   assign op_mul = (issue_op == 3'd2) || (issue_op == 3'd3);
   assign op_mem = (issue_op == 3'd4) || (issue_op == 3'd5);
   assign op_ill = issue_op[2] & issue_op[1];

   assign rob_full     = (rob_count_reg == ROB_FULL);
   assign lsq_full     = (lsq_count_reg == LSQ_FULL);
   assign add_any_free = ~(&add_busy);
   assign mul_any_free = ~(&mul_busy);

   // Descending scan so the lowest-index free station wins.
   always_comb begin
      add_sel = RS_NONE;
      for (int i = N_ADD - 1; i >= 0; i--) begin
         if (!add_busy[i]) add_sel = RSW'(ADD_BASE + i);
      end
   end

   always_comb begin
      mul_sel = RS_NONE;
      for (int i = N_MUL - 1; i >= 0; i--) begin
         if (!mul_busy[i]) mul_sel = RSW'(MUL_BASE + i);
      end
   end

   // ROB-full outranks class-full; with no instruction only the ROB is checked.
   always_comb begin
      cause = CAUSE_NONE;
      if (rob_full) begin
         cause = CAUSE_ROB;
      end else if (issue_valid) begin
         if (op_add && !add_any_free)      cause = CAUSE_RS;
         else if (op_mul && !mul_any_free) cause = CAUSE_RS;
         else if (op_mem && lsq_full)      cause = CAUSE_LSQ;
      end
   end

   assign hazard = (cause != CAUSE_NONE);

   always_comb begin
      issue_ready = start & ~flush & ~hazard;
      struct_haz  = start & issue_valid & hazard;
      haz_cause   = (start && issue_valid) ? cause : CAUSE_NONE;
      illegal_op  = issue_valid & op_ill;
      rs_idx      = RS_NONE;
      if (start && issue_valid && !hazard) begin
         if (op_add)      rs_idx = add_sel;
         else if (op_mul) rs_idx = mul_sel;
         else if (op_mem) rs_idx = RSW'(lsq_tail_reg);
      end
   end

   assign fire       = issue_valid & issue_ready;
   assign fire_mem   = fire & op_mem;
   assign do_commit  = rob_commit & (rob_count_reg != '0);
   assign do_release = lsq_release & (lsq_count_reg != '0);

   always_comb begin
      rob_head_next  = rob_head_reg;
      rob_tail_next  = rob_tail_reg;
      rob_count_next = rob_count_reg;
      lsq_tail_next  = lsq_tail_reg;
      lsq_count_next = lsq_count_reg;
      if (!start || flush) begin
         rob_head_next  = '0;
         rob_tail_next  = '0;
         rob_count_next = '0;
         lsq_tail_next  = '0;
         lsq_count_next = '0;
      end else begin
         if (fire)      rob_tail_next = rob_tail_reg + ROB_W'(1);
         if (do_commit) rob_head_next = rob_head_reg + ROB_W'(1);
         case ({fire, do_commit})
            2'b10:   rob_count_next = rob_count_reg + (ROB_W + 1)'(1);
            2'b01:   rob_count_next = rob_count_reg - (ROB_W + 1)'(1);
            default: rob_count_next = rob_count_reg;
         endcase
         // LSQ depth need not be a power of two, so wrap explicitly.
         if (fire_mem) lsq_tail_next = (lsq_tail_reg == LSQ_LAST) ? '0 : lsq_tail_reg + LSQ_W'(1);
         case ({fire_mem, do_release})
            2'b10:   lsq_count_next = lsq_count_reg + (LSQ_W + 1)'(1);
            2'b01:   lsq_count_next = lsq_count_reg - (LSQ_W + 1)'(1);
            default: lsq_count_next = lsq_count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rob_head_reg  <= '0;
         rob_tail_reg  <= '0;
         rob_count_reg <= '0;
         lsq_tail_reg  <= '0;
         lsq_count_reg <= '0;
      end else begin
         rob_head_reg  <= rob_head_next;
         rob_tail_reg  <= rob_tail_next;
         rob_count_reg <= rob_count_next;
         lsq_tail_reg  <= lsq_tail_next;
         lsq_count_reg <= lsq_count_next;
      end
   end

   assign rob_idx   = rob_tail_reg;
   assign rob_count = rob_count_reg;
   assign lsq_count = lsq_count_reg;

`ifdef ISSUE_STALL_STATS_EN
   logic [31:0] stall_rob_reg, stall_rs_reg, stall_lsq_reg, issue_cnt_reg;

   // Statistics survive flush; only reset or start=0 clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_rob_reg <= '0;
         stall_rs_reg  <= '0;
         stall_lsq_reg <= '0;
         issue_cnt_reg <= '0;
      end else if (!start) begin
         stall_rob_reg <= '0;
         stall_rs_reg  <= '0;
         stall_lsq_reg <= '0;
         issue_cnt_reg <= '0;
      end else begin
         if (struct_haz && haz_cause == CAUSE_ROB && stall_rob_reg != '1)
            stall_rob_reg <= stall_rob_reg + 32'd1;
         if (struct_haz && haz_cause == CAUSE_RS && stall_rs_reg != '1)
            stall_rs_reg <= stall_rs_reg + 32'd1;
         if (struct_haz && haz_cause == CAUSE_LSQ && stall_lsq_reg != '1)
            stall_lsq_reg <= stall_lsq_reg + 32'd1;
         if (fire && issue_cnt_reg != '1)
            issue_cnt_reg <= issue_cnt_reg + 32'd1;
      end
   end

   assign stall_rob_cnt = stall_rob_reg;
   assign stall_rs_cnt  = stall_rs_reg;
   assign stall_lsq_cnt = stall_lsq_reg;
   assign issue_cnt     = issue_cnt_reg;
`endif

endmodule
